// File: rtl/stack_pkg.sv
// Shared op encodings, FSM states and default geometry for the stack controller
// that sits in front of blockMemory16.
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CAPT
    } state_t;

    localparam int         DEFAULT_DATA_W    = 16;
    localparam int         DEFAULT_ADDR_W    = 10;
    localparam logic [9:0] DEFAULT_BASE_ADDR = 10'h200;
    localparam int         DEFAULT_DEPTH     = 256;

endpackage

// File: rtl/stack_ptr_unit.sv
// Stack occupancy counter with saturating inc/dec, full/empty decode and
// BASE_ADDR-relative address generation (modulo 2**ADDR_W).
module stack_ptr_unit #(
    parameter int               ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h200,
    parameter int               DEPTH     = 256,
    parameter int               CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr
);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Saturation is enforced here as well, so a stray inc/dec can never wrap the count.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + CNT_W'(1);
        end else if (dec && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    assign push_addr = BASE_ADDR + ADDR_W'(count);
    assign top_addr  = push_addr - ADDR_W'(1);

endmodule

// File: rtl/stack_mem_ctrl.sv
// Push/pop/peek stack controller driving blockMemory16 (1-cycle synchronous read).
// Optional macro STACK_PEEK_EN enables op 11 PEEK; without it op 11 is absorbed as a NOP.
module stack_mem_ctrl
    import stack_pkg::*;
#(
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                DEPTH     = DEFAULT_DEPTH,
    localparam int               CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    if (int'(BASE_ADDR) + DEPTH > 2 ** ADDR_W) begin : g_bad_window
        $error("stack_mem_ctrl: BASE_ADDR + DEPTH exceeds the memory address space");
    end

    state_t            state;
    logic              accept;
    logic              op_read;
    logic              inc;
    logic              dec;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top_addr;

    assign accept = req_valid && req_ready;

`ifdef STACK_PEEK_EN
    assign op_read = (req_op == OP_POP) || (req_op == OP_PEEK);
`else
    assign op_read = (req_op == OP_POP);
`endif

    // Only POP moves the pointer on a read; PEEK leaves the top of stack in place.
    assign inc = accept && (req_op == OP_PUSH) && !full;
    assign dec = accept && (req_op == OP_POP) && !empty;

    stack_ptr_unit #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) u_ptr (
        .clka      (clka),
        .rst_n     (rst_n),
        .inc       (inc),
        .dec       (dec),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_addr (push_addr),
        .top_addr  (top_addr)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= BASE_ADDR;
            mem_din       <= '0;
        end else begin
            resp_valid    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_op == OP_PUSH) begin
                            if (full) begin
                                overflow_err <= 1'b1;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= push_addr;
                                mem_din   <= req_data;
                                state     <= WRITE;
                                req_ready <= 1'b0;
                            end
                        end else if (op_read) begin
                            if (empty) begin
                                underflow_err <= 1'b1;
                            end else begin
                                mem_we    <= 1'b0;
                                mem_addr  <= top_addr;
                                state     <= RD_ADDR;
                                req_ready <= 1'b0;
                            end
                        end
                    end
                end
                WRITE: begin
                    mem_we    <= 1'b0;
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                RD_ADDR: begin
                    state <= RD_CAPT;
                end
                RD_CAPT: begin
                    resp_data  <= mem_dout;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl with a behavioural blockMemory16 model,
// a reference stack and scoreboards for memory writes and read responses.
module tb_stack_mem_ctrl;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] PEEK = 2'b11;
    localparam int         BASE  = 'h200;
    localparam int         DEPTH = 256;
`ifdef STACK_PEEK_EN
    localparam bit PEEK_EN = 1'b1;
`else
    localparam bit PEEK_EN = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = NOP;
    logic [15:0] req_data = '0;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        full;
    logic        empty;
    logic [8:0]  count;
    logic        overflow_err;
    logic        underflow_err;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    stack_mem_ctrl dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout)
    );

    always #5 clka = ~clka;

    // blockMemory16 stand-in: write on wea, registered read with one cycle of latency.
    logic [15:0] mem [0:1023];
    always @(posedge clka) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] data;
        int          cnt;
        bit          full;
        bit          empty;
        bit          resp;
        bit          ovf;
        bit          unf;
        bit          we;
        int          busy;
        int          addr;
    } vec_t;

    logic [15:0] model_q[$];
    logic [15:0] resp_q[$];
    wr_t         wr_q[$];

    int checks = 0;
    int passes = 0;
    int resp_cnt = 0;
    int ovf_cnt = 0;
    int unf_cnt = 0;
    int we_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: scores every write and response against what the stimulus predicted.
    always @(negedge clka) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                if (wr_q.size() == 0) begin
                    check_output("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check_output("write_addr", 32'(mem_addr), 32'(w.addr));
                    check_output("write_data", 32'(mem_din), 32'(w.data));
                end
            end
            if (resp_valid) begin
                resp_cnt++;
                if (resp_q.size() == 0) begin
                    check_output("unexpected_resp", 32'(resp_data), 32'hFFFF_FFFF);
                end else begin
                    check_output("resp_data", 32'(resp_data), 32'(resp_q.pop_front()));
                end
            end
            if (overflow_err) ovf_cnt++;
            if (underflow_err) unf_cnt++;
        end
    end

    task automatic model_update(input logic [1:0] op, input logic [15:0] data);
        wr_t w;
        case (op)
            PUSH: if (model_q.size() < DEPTH) begin
                w.addr = 10'(BASE + model_q.size());
                w.data = data;
                wr_q.push_back(w);
                model_q.push_back(data);
            end
            POP: if (model_q.size() > 0) resp_q.push_back(model_q.pop_back());
            PEEK: if (PEEK_EN && model_q.size() > 0) resp_q.push_back(model_q[$]);
            default: ;
        endcase
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [15:0] data, output int busy);
        @(negedge clka);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        model_update(op, data);
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        req_op    = NOP;
        busy = 0;
        while (!req_ready && busy < 10) begin
            @(posedge clka);
            #1;
            busy++;
        end
        if (!req_ready) check_output("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    vec_t vecs[10];
    int   busy;
    int   r0, o0, u0, w0;

    initial begin
        vecs[0] = '{"nop",        NOP,  16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 'h200};
        vecs[1] = '{"pop_empty",  POP,  16'h0000, 0, 0, 1, 0, 0, 1, 0, 0, 'h200};
        vecs[2] = '{"push_8888",  PUSH, 16'h8888, 1, 0, 0, 0, 0, 0, 1, 1, 'h200};
        vecs[3] = '{"push_9999",  PUSH, 16'h9999, 2, 0, 0, 0, 0, 0, 1, 1, 'h201};
        vecs[4] = '{"pop_9999",   POP,  16'h0000, 1, 0, 0, 1, 0, 0, 0, 2, 'h201};
        vecs[5] = '{"pop_8888",   POP,  16'h0000, 0, 0, 1, 1, 0, 0, 0, 2, 'h200};
        vecs[6] = '{"peek_empty", PEEK, 16'h0000, 0, 0, 1, 0, 0, PEEK_EN, 0, 0, 'h200};
        vecs[7] = '{"push_1000",  PUSH, 16'h1000, 1, 0, 0, 0, 0, 0, 1, 1, 'h200};
        vecs[8] = '{"peek_1000",  PEEK, 16'h0000, 1, 0, 0, PEEK_EN, 0, 0, 0, PEEK_EN ? 2 : 0, 'h200};
        vecs[9] = '{"pop_1000",   POP,  16'h0000, 0, 0, 1, 1, 0, 0, 0, 2, 'h200};

        #12;
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_empty", 32'(empty), 32'd1);
        check_output("rst_full", 32'(full), 32'd0);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'h200);
        check_output("rst_req_ready", 32'(req_ready), 32'd1);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_errs", 32'({overflow_err, underflow_err}), 32'd0);
        @(negedge clka);
        rst_n = 1'b1;
        repeat (2) @(negedge clka);
        #1;
        check_output("idle_count", 32'(count), 32'd0);
        check_output("idle_pulses", 32'(resp_cnt + ovf_cnt + unf_cnt + we_cnt), 32'd0);

        for (int i = 0; i < 10; i++) begin
            r0 = resp_cnt; o0 = ovf_cnt; u0 = unf_cnt; w0 = we_cnt;
            apply_stimulus(vecs[i].op, vecs[i].data, busy);
            @(negedge clka);
            #1;
            check_output({vecs[i].name, "_count"}, 32'(count), 32'(vecs[i].cnt));
            check_output({vecs[i].name, "_full"}, 32'(full), 32'(vecs[i].full));
            check_output({vecs[i].name, "_empty"}, 32'(empty), 32'(vecs[i].empty));
            check_output({vecs[i].name, "_resp"}, 32'(resp_cnt - r0), 32'(vecs[i].resp));
            check_output({vecs[i].name, "_ovf"}, 32'(ovf_cnt - o0), 32'(vecs[i].ovf));
            check_output({vecs[i].name, "_unf"}, 32'(unf_cnt - u0), 32'(vecs[i].unf));
            check_output({vecs[i].name, "_we"}, 32'(we_cnt - w0), 32'(vecs[i].we));
            check_output({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].busy));
            check_output({vecs[i].name, "_addr"}, 32'(mem_addr), 32'(vecs[i].addr));
        end

        // Fill to capacity, then one more push must be refused.
        for (int i = 0; i < DEPTH; i++) apply_stimulus(PUSH, 16'(i * 3 + 7), busy);
        @(negedge clka);
        #1;
        check_output("fill_count", 32'(count), 32'd256);
        check_output("fill_full", 32'(full), 32'd1);
        check_output("fill_empty", 32'(empty), 32'd0);
        o0 = ovf_cnt; w0 = we_cnt;
        apply_stimulus(PUSH, 16'h5656, busy);
        @(negedge clka);
        #1;
        check_output("ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
        check_output("ovf_no_write", 32'(we_cnt - w0), 32'd0);
        check_output("ovf_full", 32'(full), 32'd1);
        check_output("ovf_count", 32'(count), 32'd256);
        check_output("ovf_busy", 32'(busy), 32'd0);
        r0 = resp_cnt;
        apply_stimulus(POP, 16'h0000, busy);
        @(negedge clka);
        #1;
        check_output("pop_full_resp", 32'(resp_cnt - r0), 32'd1);
        check_output("pop_full_count", 32'(count), 32'd255);
        check_output("pop_full_addr", 32'(mem_addr), 32'h2FF);
        check_output("pop_full_full", 32'(full), 32'd0);

        // Reset lands while the POP is in RD_ADDR: no response may follow.
        @(negedge clka);
        req_valid = 1'b1;
        req_op    = POP;
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        req_op    = NOP;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        resp_q.delete();
        wr_q.delete();
        check_output("midrst_count", 32'(count), 32'd0);
        check_output("midrst_ready", 32'(req_ready), 32'd1);
        check_output("midrst_addr", 32'(mem_addr), 32'h200);
        check_output("midrst_resp_valid", 32'(resp_valid), 32'd0);
        r0 = resp_cnt;
        @(negedge clka);
        rst_n = 1'b1;
        repeat (4) @(negedge clka);
        #1;
        check_output("midrst_no_resp", 32'(resp_cnt - r0), 32'd0);
        check_output("midrst_empty", 32'(empty), 32'd1);

        apply_stimulus(PUSH, 16'hABCD, busy);
        r0 = resp_cnt;
        apply_stimulus(POP, 16'h0000, busy);
        @(negedge clka);
        #1;
        check_output("post_rst_resp", 32'(resp_cnt - r0), 32'd1);
        check_output("post_rst_count", 32'(count), 32'd0);
        check_output("post_rst_busy", 32'(busy), 32'd2);

        check_output("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check_output("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
